node_port_arbiter: RTL
======================

NODE_PORT_ARBITER -- requirements
Module: node_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of local requesters sharing one router_core injection port (2..8).
REQ-002 Parameter R_ADDR, default 4'b0000, address of the attached router; packets addressed to it are illegal.
REQ-003 Parameter ACK_TIMEOUT, default 1023, maximum OFFER cycles before abandoning a packet (10-bit timer).
REQ-004 Clk_R  in  1  router core clock; all state changes on rising edge.
REQ-005 Rst  in  1  reset, asynchronous, active-high.
REQ-006 Req_Valid  in  NUM_REQ  per-requester packet request, held until Req_Ready or Req_Err.
REQ-007 Req_Packet  in  29*NUM_REQ  requester i at [29*i+28:29*i]; format {dest[3:0], flag, data[23:0]}.
REQ-008 Req_Ready  out  NUM_REQ  one-cycle pulse: packet accepted by core.
REQ-009 Req_Err  out  NUM_REQ  one-cycle pulse: packet dropped (self-address or timeout).
REQ-010 Packet_From_Node_Valid  out  1  offer to router_core.
REQ-011 Packet_From_Node  out  29  offered packet.
REQ-012 Core_Load_Ack  in  1  router_core acceptance; may be a pulse or a level.
REQ-013 Grant_Id  out  clog2(NUM_REQ)  index of the current or last granted requester.
REQ-014 Busy  out  1  high in any state other than IDLE.
REQ-015 Timeout_Count  out  8  saturating count of timeouts.

Function
REQ-016 FSM states: IDLE, CHECK, OFFER, RELEASE; all outputs are registered.
REQ-017 IDLE: if any Req_Valid bit is set, pick round-robin starting at last_grant+1 (mod NUM_REQ), latch that packet and its index into Grant_Id, then go to CHECK; otherwise stay in IDLE.
REQ-018 CHECK: if latched dest == R_ADDR, pulse Req_Err[Grant_Id], advance last_grant, go to IDLE; else go to OFFER.
REQ-019 OFFER: Packet_From_Node_Valid = 1 and Packet_From_Node = latched packet; timer clears on entry and increments each OFFER cycle.
REQ-020 OFFER with Core_Load_Ack = 1: pulse Req_Ready[Grant_Id], advance last_grant, go to RELEASE.
REQ-021 OFFER with timer == ACK_TIMEOUT and no ack: pulse Req_Err[Grant_Id], increment Timeout_Count (saturate at 255), advance last_grant, go to IDLE; valid is therefore high for ACK_TIMEOUT+1 cycles.
REQ-022 Ack and timeout in the same cycle: ack wins.
REQ-023 RELEASE: Packet_From_Node_Valid = 0; stay until Core_Load_Ack = 0, then go to IDLE; a level ack yields exactly one Req_Ready.
REQ-024 Latency: Req_Valid sampled in IDLE at cycle 0 -> Packet_From_Node_Valid high from cycle 2.
REQ-025 The latched copy is used for the whole transaction; a requester dropping Req_Valid or changing Req_Packet mid-transaction does not affect the offer.
REQ-026 Req_Valid is not sampled outside IDLE; at most one Req_Ready/Req_Err bit is high in any cycle.
REQ-027 Packet_From_Node holds its last value when valid is low.

Reset
REQ-028 While Rst = 1: state = IDLE, all outputs = 0, last_grant = NUM_REQ-1 (requester 0 served first), timer = 0, Timeout_Count = 0.
REQ-029 Reset mid-transaction abandons the latched packet with no Req_Ready or Req_Err pulse.

Structure
REQ-030 Shared package router_pkg holds: packet width 29, dest field [28:25], the FSM state encoding, and the NUM_REQ default.
REQ-031 One sub-module, rr_picker: combinational round-robin selector taking (request vector, last_grant) and returning (grant index, any).

Verification
REQ-032 Req 0 packet {4'b0001,0,24'd42}, ack 3 cycles after offer -> Packet_From_Node = 29'h200002A from cycle 2, one Req_Ready[0] pulse, Grant_Id = 0.
REQ-033 All four Req_Valid held, ack on the first OFFER cycle each time -> grant order 0,1,2,3,0.
REQ-034 Req 2 packet {4'b0000,0,24'd69}, R_ADDR = 0 -> Req_Err[2] pulse, Packet_From_Node_Valid never high.
REQ-035 ACK_TIMEOUT = 15, no ack -> valid high exactly 16 cycles, Req_Err pulse, Timeout_Count = 1; 300 repeats -> Timeout_Count = 255.
REQ-036 Core_Load_Ack held high 5 cycles -> single Req_Ready, no new offer until ack is low.
REQ-037 Rst asserted in OFFER -> valid drops immediately, no Req_Ready/Req_Err; after release, requester 0 is served first.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: definitions shared by the node-side router blocks.
//   PKT_W            packet width {dest[3:0], flag, data[23:0]}
//   DEST_MSB/LSB     position of the destination field inside a packet
//   NUM_REQ_DEFAULT  default number of local requesters per injection port
//   arb_state_e      state encoding of the node port arbiter FSM
//   pkt_dest()       extracts the destination field from a packet
package router_pkg;

  localparam int PKT_W           = 29;
  localparam int DEST_MSB        = 28;
  localparam int DEST_LSB        = 25;
  localparam int NUM_REQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_OFFER   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  function automatic logic [3:0] pkt_dest(input logic [PKT_W-1:0] pkt);
    return pkt[DEST_MSB:DEST_LSB];
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req         in   request vector, one bit per requester
//   last_grant  in   index served most recently; search starts one above it
//   grant       out  index of the first set request at or after last_grant+1
//   any         out  at least one request bit is set
module rr_picker
  import router_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] grant,
  output logic                       any
);

  localparam int GW = $clog2(NUM_REQ);

  // One spare bit so last_grant + offset can exceed NUM_REQ before wrapping.
  logic [GW:0] cand;

  // Walk offsets 1..NUM_REQ from last_grant; the first hit wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + (GW+1)'(k);
      if (cand >= (GW+1)'(NUM_REQ)) begin
        cand = cand - (GW+1)'(NUM_REQ);
      end else begin
        cand = cand;
      end
      if (!any && req[cand[GW-1:0]]) begin
        grant = cand[GW-1:0];
        any   = 1'b1;
      end else begin
        any   = any;
      end
    end
  end

endmodule

// File: rtl/node_port_arbiter.sv
// node_port_arbiter: shares one router_core injection port among NUM_REQ
// local requesters. A request is picked round-robin, latched, checked for a
// self-addressed destination, offered to the core until acked or timed out,
// and the requester is told the outcome with a one-cycle pulse.
//   Clk_R / Rst                     clock, async active-high reset
//   Req_Valid / Req_Packet          per-requester requests and packets
//   Req_Ready / Req_Err             per-requester accept / drop pulses
//   Packet_From_Node_Valid / _From_Node  offer towards router_core
//   Core_Load_Ack                   core acceptance (pulse or level)
//   Grant_Id                        current or last granted requester
//   Busy                            FSM not in IDLE
//   Timeout_Count                   saturating count of timed-out offers
module node_port_arbiter
  import router_pkg::*;
#(
  parameter int         NUM_REQ     = NUM_REQ_DEFAULT,
  parameter logic [3:0] R_ADDR      = 4'b0000,
  parameter int         ACK_TIMEOUT = 1023
) (
  input  logic                         Clk_R,
  input  logic                         Rst,
  input  logic [NUM_REQ-1:0]           Req_Valid,
  input  logic [PKT_W*NUM_REQ-1:0]     Req_Packet,
  output logic [NUM_REQ-1:0]           Req_Ready,
  output logic [NUM_REQ-1:0]           Req_Err,
  output logic                         Packet_From_Node_Valid,
  output logic [PKT_W-1:0]             Packet_From_Node,
  input  logic                         Core_Load_Ack,
  output logic [$clog2(NUM_REQ)-1:0]   Grant_Id,
  output logic                         Busy,
  output logic [7:0]                   Timeout_Count
);

  localparam int GW = $clog2(NUM_REQ);

  arb_state_e           state_q, state_d;
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [PKT_W-1:0]     pkt_q, pkt_d;
  logic [PKT_W-1:0]     pfn_q, pfn_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic [9:0]           timer_q, timer_d;
  logic [7:0]           tcnt_q, tcnt_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic [NUM_REQ-1:0]   err_q, err_d;

  logic [GW-1:0]        pick;
  logic                 pick_any;
  logic [PKT_W-1:0]     pkt_arr [NUM_REQ];
  logic                 self_addr;
  logic                 timed_out;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_rr_picker (
    .req        (Req_Valid),
    .last_grant (last_grant_q),
    .grant      (pick),
    .any        (pick_any)
  );

  // Split the flat packet bus into one entry per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pkt_arr[i] = Req_Packet[PKT_W*i +: PKT_W];
    end
  end

  assign self_addr = (pkt_dest(pkt_q) == R_ADDR);
  assign timed_out = (timer_q == 10'(ACK_TIMEOUT));

  // State register.
  always_ff @(posedge Clk_R or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) state_d = ST_CHECK;
        else          state_d = ST_IDLE;
      end
      ST_CHECK: begin
        if (self_addr) state_d = ST_IDLE;
        else           state_d = ST_OFFER;
      end
      ST_OFFER: begin
        if (Core_Load_Ack)  state_d = ST_RELEASE;
        else if (timed_out) state_d = ST_IDLE;
        else                state_d = ST_OFFER;
      end
      ST_RELEASE: begin
        if (!Core_Load_Ack) state_d = ST_IDLE;
        else                state_d = ST_RELEASE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; outputs are derived from state_d so
  // that the registered copies line up with the state they describe.
  always_comb begin
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    pkt_d        = pkt_q;
    timer_d      = timer_q;
    tcnt_d       = tcnt_q;
    ready_d      = '0;
    err_d        = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick;
          pkt_d   = pkt_arr[pick];
        end else begin
          grant_d = grant_q;
        end
      end
      ST_CHECK: begin
        timer_d = '0;
        if (self_addr) begin
          err_d[grant_q] = 1'b1;
          last_grant_d   = grant_q;
        end else begin
          last_grant_d   = last_grant_q;
        end
      end
      ST_OFFER: begin
        timer_d = timer_q + 10'd1;
        if (Core_Load_Ack) begin
          ready_d[grant_q] = 1'b1;
          last_grant_d     = grant_q;
        end else if (timed_out) begin
          err_d[grant_q] = 1'b1;
          last_grant_d   = grant_q;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          else                 tcnt_d = tcnt_q;
        end else begin
          last_grant_d = last_grant_q;
        end
      end
      ST_RELEASE: begin
        timer_d = timer_q;
      end
      default: begin
        timer_d = timer_q;
      end
    endcase
    valid_d = (state_d == ST_OFFER);
    busy_d  = (state_d != ST_IDLE);
    if (state_d == ST_OFFER) pfn_d = pkt_q;
    else                     pfn_d = pfn_q;
  end

  // Datapath and registered outputs.
  always_ff @(posedge Clk_R or posedge Rst) begin
    if (Rst) begin
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_q      <= '0;
      pkt_q        <= '0;
      pfn_q        <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      timer_q      <= '0;
      tcnt_q       <= '0;
      ready_q      <= '0;
      err_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      pkt_q        <= pkt_d;
      pfn_q        <= pfn_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      timer_q      <= timer_d;
      tcnt_q       <= tcnt_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
    end
  end

  assign Req_Ready              = ready_q;
  assign Req_Err                = err_q;
  assign Packet_From_Node_Valid = valid_q;
  assign Packet_From_Node       = pfn_q;
  assign Grant_Id               = grant_q;
  assign Busy                   = busy_q;
  assign Timeout_Count          = tcnt_q;

endmodule
